// File: rtl/sr_shift_ctrl_if.sv
// sr_shift_ctrl_if: word-load handshake, abort and serial-link outputs of the
// shift controller.
// The master side is the word producer and serial consumer. The slave side
// is the controller.
interface sr_shift_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             abort;
  logic             serial_out;
  logic             frame;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, abort,
    input  load_ready, serial_out, frame, busy, done
  );

  modport slave (
    input  load_valid, load_data, abort,
    output load_ready, serial_out, frame, busy, done
  );
endinterface

// File: rtl/sr_shift_ctrl.sv
// sr_shift_ctrl: accepts parallel words over valid/ready, serialises each one
// bit per clock with a frame qualifier, pulses done after a completed frame,
// then inserts GAP_CYCLES idle cycles.
// The done cycle counts as the first gap cycle. When GAP_CYCLES is 0, the done
// cycle is an IDLE cycle, so accept-to-accept spacing is WIDTH+GAP_CYCLES+1.
// Optional macro SR_SHIFT_CTRL_PARITY_EN appends an even-parity bit after the
// data bits, which makes each frame one bit longer.
module sr_shift_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_shift_ctrl_if.slave bus
);

`ifdef SR_SHIFT_CTRL_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [3:0] C_GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_gap, w_gap_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_serial, w_serial_nxt;
  logic             r_frame, w_frame_nxt;
  logic             r_done, w_done_nxt;
  logic             w_load_ready;
  logic             w_accept;
`ifdef SR_SHIFT_CTRL_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  // Bit that leaves the word first, given the transmit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Word with the transmitted bit removed and a zero filled in behind it.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign w_load_ready = (r_state == S_IDLE) && rst_n && !bus.abort;
  assign w_accept     = w_load_ready && bus.load_valid;

  assign bus.load_ready = w_load_ready;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.serial_out = r_serial;
  assign bus.frame      = r_frame;
  assign bus.done       = r_done;

  // Next-state and next-output decode. The outputs are registered, so the
  // first bit is presented in the cycle right after the accept edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = r_gap;
    w_shreg_nxt  = r_shreg;
    w_serial_nxt = 1'b0;
    w_frame_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
`ifdef SR_SHIFT_CTRL_PARITY_EN
    w_par_nxt    = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = S_SHIFT;
          w_cnt_nxt    = '0;
          w_shreg_nxt  = shift_word(bus.load_data);
          w_serial_nxt = head_bit(bus.load_data);
          w_frame_nxt  = 1'b1;
`ifdef SR_SHIFT_CTRL_PARITY_EN
          w_par_nxt    = ^bus.load_data;
`endif
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_LAST_IDX) begin
          // The last bit is on the line now, so done goes out next cycle.
          w_done_nxt  = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else begin
          w_cnt_nxt    = r_cnt + 1'b1;
          w_frame_nxt  = 1'b1;
          w_serial_nxt = head_bit(r_shreg);
          w_shreg_nxt  = shift_word(r_shreg);
`ifdef SR_SHIFT_CTRL_PARITY_EN
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_serial_nxt = r_par;
          end
`endif
        end
      end
      S_GAP: begin
        if (bus.abort || (r_gap == C_GAP_LAST)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_shreg  <= '0;
      r_serial <= 1'b0;
      r_frame  <= 1'b0;
      r_done   <= 1'b0;
`ifdef SR_SHIFT_CTRL_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_shreg  <= w_shreg_nxt;
      r_serial <= w_serial_nxt;
      r_frame  <= w_frame_nxt;
      r_done   <= w_done_nxt;
`ifdef SR_SHIFT_CTRL_PARITY_EN
      r_par    <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// tb_sr_shift_ctrl: directed bench with three controller instances.
// A is MSB-first with a gap of 1, B is LSB-first with a gap of 1, and C is
// MSB-first with no gap. Expected bit streams are written out by hand.
// Bit i of each stream constant is the i-th transmitted bit, and bit 8 is the
// even-parity bit, which is used only when SR_SHIFT_CTRL_PARITY_EN is defined.
module tb_sr_shift_ctrl;
`ifdef SR_SHIFT_CTRL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  logic       abrt;
  int         sel;

  sr_shift_ctrl_if #(.WIDTH(8)) if_a ();
  sr_shift_ctrl_if #(.WIDTH(8)) if_b ();
  sr_shift_ctrl_if #(.WIDTH(8)) if_c ();

  assign if_a.load_valid = (sel == 0) && valid;
  assign if_b.load_valid = (sel == 1) && valid;
  assign if_c.load_valid = (sel == 2) && valid;
  assign if_a.abort      = (sel == 0) && abrt;
  assign if_b.abort      = (sel == 1) && abrt;
  assign if_c.abort      = (sel == 2) && abrt;
  assign if_a.load_data  = data;
  assign if_b.load_data  = data;
  assign if_c.load_data  = data;

  sr_shift_ctrl #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  sr_shift_ctrl #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  sr_shift_ctrl #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic o_ser, o_frm, o_rdy, o_bsy, o_don;
  always_comb begin
    o_ser = if_a.serial_out; o_frm = if_a.frame; o_rdy = if_a.load_ready;
    o_bsy = if_a.busy;       o_don = if_a.done;
    if (sel == 1) begin
      o_ser = if_b.serial_out; o_frm = if_b.frame; o_rdy = if_b.load_ready;
      o_bsy = if_b.busy;       o_don = if_b.done;
    end else if (sel == 2) begin
      o_ser = if_c.serial_out; o_frm = if_c.frame; o_rdy = if_c.load_ready;
      o_bsy = if_c.busy;       o_don = if_c.done;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated frame on A or B, followed by the done/gap cycle and IDLE.
  task automatic run_frame(input int s, input logic [7:0] d, input logic [8:0] bits);
    sel = s; data = d; valid = 1'b1; #1;
    check("rdy_before_accept", o_rdy, 1);
    tick();
    valid = 1'b0; #1;
    for (int i = 0; i < FL; i++) begin
      check($sformatf("frame_b%0d", i), o_frm, 1);
      check($sformatf("serial_b%0d", i), o_ser, bits[i]);
      check($sformatf("rdy_b%0d", i), o_rdy, 0);
      check($sformatf("done_b%0d", i), o_don, 0);
      tick();
    end
    check("done_pulse", o_don, 1);
    check("frame_at_done", o_frm, 0);
    check("serial_at_done", o_ser, 0);
    check("rdy_at_done", o_rdy, 0);
    tick();
    check("done_cleared", o_don, 0);
    check("rdy_after_gap", o_rdy, 1);
    check("busy_after_gap", o_bsy, 0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; abrt = 1'b0; data = 8'h00; sel = 0;
    // Reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int s = 0; s < 3; s++) begin
        sel = s; #1;
        check("rst_rdy", o_rdy, 0);
        check("rst_frame", o_frm, 0);
        check("rst_serial", o_ser, 0);
        check("rst_done", o_don, 0);
        check("rst_busy", o_bsy, 0);
      end
    end
    rst_n = 1'b1; sel = 0;
    tick();
    check("idle_rdy", o_rdy, 1);
    check("idle_busy", o_bsy, 0);
    check("idle_frame", o_frm, 0);

    // MSB-first 0xC1: 1,1,0,0,0,0,0,1 and parity 1
    run_frame(0, 8'hC1, 9'h183);
    // LSB-first 0xC1: 1,0,0,0,0,0,1,1 and parity 1
    run_frame(1, 8'hC1, 9'h1C1);
`ifdef SR_SHIFT_CTRL_PARITY_EN
    // MSB-first 0x03: 0,0,0,0,0,0,1,1 and parity 0
    run_frame(0, 8'h03, 9'h0C0);
`endif

    // Back-to-back on C: 0x0F, then 0xF0 accepted in the done cycle
    sel = 2; data = 8'h0F; valid = 1'b1; #1;
    tick();
    data = 8'hF0; #1;
    for (int i = 0; i < FL; i++) begin
      check("b2b_frame1", o_frm, 1);
      check("b2b_serial1", o_ser, (9'h0F0 >> i) & 1);
      check("b2b_rdy1", o_rdy, 0);
      tick();
    end
    check("b2b_done1", o_don, 1);
    check("b2b_frame_gap", o_frm, 0);
    check("b2b_rdy_done", o_rdy, 1);
    tick();
    for (int i = 0; i < FL; i++) begin
      if (i == 0) valid = 1'b0;
      check("b2b_frame2", o_frm, 1);
      check("b2b_serial2", o_ser, (9'h00F >> i) & 1);
      check("b2b_done2_low", o_don, 0);
      tick();
    end
    check("b2b_done2", o_don, 1);
    tick();
    check("b2b_idle_busy", o_bsy, 0);
    check("b2b_idle_frame", o_frm, 0);

    // Abort during the 4th bit of 0xAA on A
    sel = 0; data = 8'hAA; valid = 1'b1; #1;
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    check("abort_frame_4th", o_frm, 1);
    check("abort_serial_4th", o_ser, 0);
    abrt = 1'b1;
    tick();
    abrt = 1'b0; #1;
    check("abort_frame", o_frm, 0);
    check("abort_serial", o_ser, 0);
    check("abort_busy", o_bsy, 0);
    check("abort_rdy", o_rdy, 1);
    for (int i = 0; i < FL + 2; i++) begin
      check("abort_no_done", o_don, 0);
      tick();
    end

    // Abort in IDLE takes priority over the handshake
    data = 8'h55; valid = 1'b1; abrt = 1'b1; #1;
    check("abort_idle_rdy", o_rdy, 0);
    tick();
    valid = 1'b0; abrt = 1'b0; #1;
    check("abort_idle_busy", o_bsy, 0);

    // Reset in the middle of a frame
    data = 8'hAA; valid = 1'b1; #1;
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst_frame", o_frm, 0);
    check("midrst_serial", o_ser, 0);
    check("midrst_busy", o_bsy, 0);
    check("midrst_rdy", o_rdy, 0);
    check("midrst_shreg", dut_a.r_shreg, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_rdy_after", o_rdy, 1);
    for (int i = 0; i < FL + 2; i++) begin
      check("midrst_no_done", o_don, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
